// File: rtl/if_stage_fetch_unit.sv
// Instruction-fetch stage: PC register, next-PC select and the IF/ID pipeline
// register, plus saturating stall/flush debug counters.
module if_stage_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000,
    parameter int unsigned CNT_W     = 16
) (
    input  logic             CLK,
    input  logic             Reset,
    input  logic             PCWre,
    input  logic             IF_ID_Wre,
    input  logic             ID_Jump,
    input  logic [31:0]      ID_Jump_Target,
    input  logic             ID_Branch_Taken,
    input  logic [31:0]      ID_Branch_Target,
    input  logic [31:0]      IM_Instr,
    output logic [31:0]      IM_Addr,
    output logic [31:0]      IF_PC,
    output logic [31:0]      ID_Instr,
    output logic [31:0]      ID_PC4,
    output logic             ID_Valid,
    output logic [CNT_W-1:0] Stall_Count,
    output logic [CNT_W-1:0] Flush_Count
);

    localparam logic [31:0]      ALIGN_MASK = ~32'h3;
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX    = '1;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc4;
        logic        valid;
    } ifid_t;

    localparam ifid_t IFID_BUBBLE = '{instr: NOP_INSTR, pc4: 32'h0, valid: 1'b0};

    logic [31:0]      pc_q, pc_d;
    logic [31:0]      pc_plus4;
    logic [31:0]      redirect_pc;
    logic             redirect;
    logic             flush;
    ifid_t            ifid_q, ifid_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    assign pc_plus4    = pc_q + 32'd4;
    assign redirect    = ID_Jump | ID_Branch_Taken;
    // Jump beats branch; both targets are word-aligned before use.
    assign redirect_pc = ID_Jump ? (ID_Jump_Target & ALIGN_MASK)
                                 : (ID_Branch_Target & ALIGN_MASK);
    // A stalled IF/ID keeps the branch in ID, so it is only flushed once released.
    assign flush       = IF_ID_Wre & redirect;

    always_comb begin
        pc_d = pc_q;
        if (PCWre) begin
            pc_d = redirect ? redirect_pc : pc_plus4;
        end
    end

    always_comb begin
        ifid_d = ifid_q;
        if (IF_ID_Wre) begin
            if (redirect) begin
                ifid_d = IFID_BUBBLE;
            end else begin
                ifid_d = '{instr: IM_Instr, pc4: pc_plus4, valid: 1'b1};
            end
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (!IF_ID_Wre && stall_cnt_q != CNT_MAX) begin
            stall_cnt_d = stall_cnt_q + CNT_ONE;
        end
        if (flush && flush_cnt_q != CNT_MAX) begin
            flush_cnt_d = flush_cnt_q + CNT_ONE;
        end
    end

    always_ff @(posedge CLK) begin
        if (!Reset) begin
            pc_q        <= RESET_PC;
            ifid_q      <= IFID_BUBBLE;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            pc_q        <= pc_d;
            ifid_q      <= ifid_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign IM_Addr     = pc_q;
    assign IF_PC       = pc_q;
    assign ID_Instr    = ifid_q.instr;
    assign ID_PC4      = ifid_q.pc4;
    assign ID_Valid    = ifid_q.valid;
    assign Stall_Count = stall_cnt_q;
    assign Flush_Count = flush_cnt_q;

endmodule

// File: doc/if_stage_fetch_unit.md
Name: if_stage_fetch_unit

Overview:
- Instruction-fetch stage together with the IF/ID pipeline register. Sits directly downstream of the load-use hazard detection logic and consumes its PCWre and IF_ID_Wre outputs.
- Holds the PC, drives the instruction-memory address, and selects the next PC from sequential, branch-target or jump-target sources.
- Registers the fetched instruction and PC+4 into ID, inserting a NOP bubble on a taken control transfer.
- Keeps saturating stall and flush event counters for debug.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INSTR, 32'h0000_0000, instruction word injected into ID on reset or flush.
- CNT_W, 16, width of the stall and flush counters.

Ports:
- CLK  input  1  Clock; all state updates on the rising edge.
- Reset  input  1  Synchronous, active-low reset (0 = reset, sampled on the CLK rising edge).
- PCWre  input  1  PC write enable from the hazard unit; 0 holds the PC.
- IF_ID_Wre  input  1  IF/ID write enable from the hazard unit; 0 holds the ID outputs.
- ID_Jump  input  1  Jump resolved in ID.
- ID_Jump_Target  input  32  Jump destination.
- ID_Branch_Taken  input  1  Branch resolved taken in ID.
- ID_Branch_Target  input  32  Branch destination.
- IM_Instr  input  32  Instruction word returned by instruction memory for IM_Addr (same-cycle, combinational memory).
- IM_Addr  output  32  Instruction-memory address; equals the PC, driven combinationally from the PC register.
- IF_PC  output  32  Current PC (same value as IM_Addr, exported for debug).
- ID_Instr  output  32  Registered instruction presented to decode.
- ID_PC4  output  32  Registered PC+4 of ID_Instr.
- ID_Valid  output  1  1 when ID_Instr is a real fetched instruction; 0 for a bubble.
- Stall_Count  output  CNT_W  Cycles with IF_ID_Wre=0 since reset.
- Flush_Count  output  CNT_W  Flushes applied since reset.

Behaviour:
- Reset (Reset=0 at a rising edge), with priority over all other inputs:
  - PC <= RESET_PC.
  - ID_Instr <= NOP_INSTR, ID_PC4 <= 0, ID_Valid <= 0.
  - Stall_Count <= 0, Flush_Count <= 0.
  - Reset asserted mid-stall or mid-redirect discards that event.
- Redirect:
  - redirect = ID_Jump | ID_Branch_Taken.
  - Jump has priority over branch when both are asserted.
  - Target bits [1:0] are forced to 00 before use.
- PC update, evaluated per edge in this order:
  - PCWre=0: hold the PC.
  - Else if ID_Jump: PC <= {ID_Jump_Target[31:2], 2'b00}.
  - Else if ID_Branch_Taken: PC <= {ID_Branch_Target[31:2], 2'b00}.
  - Else: PC <= PC+4, modulo 2^32 (32'hFFFF_FFFC wraps to 0).
- IF/ID update, evaluated per edge in this order:
  - IF_ID_Wre=0: hold ID_Instr, ID_PC4 and ID_Valid. Stall wins over redirect; the stalled ID instruction re-presents its branch/jump next cycle.
  - Else if redirect: flush. ID_Instr <= NOP_INSTR, ID_PC4 <= 0, ID_Valid <= 0.
  - Else: ID_Instr <= IM_Instr, ID_PC4 <= PC+4, ID_Valid <= 1.
- Stall priority over redirect: with PCWre=0 and redirect=1, the PC holds (redirect ignored that cycle). Redirect takes effect on the first edge with PCWre=1.
- PCWre and IF_ID_Wre are handled independently. With PCWre=1 and IF_ID_Wre=0, the PC advances and the fetched word is dropped; the hazard unit guarantees the two are equal in normal operation.
- Latency:
  - One cycle from IM_Addr to ID_Instr.
  - Redirect costs exactly one bubble: the instruction fetched alongside the taken transfer is flushed.
- Counters:
  - Stall_Count increments on each non-reset edge with IF_ID_Wre=0.
  - Flush_Count increments on each edge where a flush is applied.
  - Both saturate at all-ones and never wrap.
- No combinational path from IM_Instr to any output.

Test Plan:
- Reset=0 for 2 cycles, then release -> IM_Addr=0, ID_Valid=0, ID_Instr=NOP; next edge ID_Instr=mem[0], ID_PC4=4, ID_Valid=1; IM_Addr=4, 8, 12 on successive cycles.
- At PC=0x10, hold PCWre=IF_ID_Wre=0 for 2 cycles -> IM_Addr stays 0x10, ID outputs frozen, Stall_Count=2; on release, fetch resumes at 0x10 with no instruction lost.
- ID_Branch_Taken=1, target 0x43 at PC=0x20 -> next PC=0x40, ID_Valid=0 with ID_Instr=NOP for one cycle, Flush_Count=1, then ID_Instr=mem[0x40].
- ID_Jump=1 (target 0x100) and ID_Branch_Taken=1 (target 0x200) together -> PC=0x100.
- PCWre=IF_ID_Wre=0 with ID_Branch_Taken=1 for one cycle, then stall released with the branch still asserted -> PC holds during the stall, redirects on the following edge, Flush_Count increments once.
- Edge cases, run separately:
  - PC=0xFFFF_FFFC sequential fetch -> PC=0.
  - CNT_W=2 with 5 stall cycles -> Stall_Count=3.
  - Reset asserted during a stall -> all outputs at reset values next edge.
